popcount_weight_enumerator: RTL and testbench
=============================================

Name: popcount_weight_enumerator

Overview:
Sequential stimulus source for characterising the approximate popcount cores. It takes a requested Hamming weight k and streams every N-bit input vector with exactly k ones, in ascending numeric order, over a valid/ready handshake. It drives the DUT inputs in the exhaustive-per-weight error evaluation harness, which computes MAE, WCE and EP.

Parameters:
N, 23, vector width (input width of the popcount under test); legal range 2..31
W, 5, width of the weight port; must satisfy 2^W > N

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a new enumeration; sampled only in IDLE
weight  input  W  requested Hamming weight k; sampled with start
busy  output  1  high from accepted start until done
out_vector  output  N  current vector, weight exactly k
out_valid  output  1  out_vector is valid
out_ready  input  1  consumer accepts out_vector when out_valid & out_ready
out_last  output  1  high with the final vector of the enumeration
done  output  1  one-cycle pulse after the final handshake
error  output  1  one-cycle pulse when start is rejected for weight > N

Behaviour:
- Reset value of every output is 0: out_vector, out_valid, out_last, busy, done and error. FSM goes to IDLE.
- Reset is asynchronous: asserting rst_n mid-run aborts immediately. No done pulse; the enumeration must be restarted.
- FSM states: IDLE, EMIT, FIN.
- IDLE, start=1, weight<=N: load v = (1<<k)-1, out_valid=1 and busy=1 on the next edge, go to EMIT. Latency from start to the first valid vector is 1 cycle.
- IDLE, start=1, weight>N: error=1 for one cycle, stay in IDLE, no vectors emitted.
- start while not IDLE is ignored; weight is ignored unless accepted.
- EMIT without a handshake: out_vector, out_valid and out_last hold stable (AXI-style; valid never drops before ready).
- EMIT with a handshake and out_last=0: on the same edge, out_vector gets the Gosper successor, and out_valid stays 1. Back-to-back throughput is one vector per cycle.
- Gosper successor:
  - c = v & -v
  - r = v + c
  - next = r | (((v ^ r) >> 2) >> ctz(c))
  - All arithmetic is N+1 bits wide; the result is truncated to N bits.
  - ctz is computed by a priority encoder (no divider).
- out_last = (v == ((1<<k)-1) << (N-k)), evaluated combinationally from the registered v and k.
- EMIT with a handshake and out_last=1: out_valid=0, go to FIN.
- FIN: done=1 for one cycle, busy=0, return to IDLE. A new start is accepted in the cycle after done.
- Corner cases:
  - k=0 emits exactly one vector, 0, with out_last=1.
  - k=N emits exactly one vector, all ones, with out_last=1.
- Total vectors emitted = C(N,k). No vector is repeated or skipped, and the sequence is strictly increasing.

Optional Feature:
Macro ENUM_VECTOR_COUNT_EN.
- Defined:
  - Adds output emit_count [24:0], which counts handshakes since the last accepted start (clears on accepted start, resets to 0).
  - Adds output count_ok, registered with done, which is high iff emit_count equals C(N,k). C(N,k) comes from a synthesis-time lookup table indexed by k.
- Undefined: neither port exists, and no counter or table is synthesised.

Test Plan:
- weight=2, out_ready=1: first four vectors 0x000003, 0x000005, 0x000006, 0x000009; last 0x600000 with out_last=1; 253 vectors total; done one cycle later.
- weight=1, out_ready=1: vectors 0x000001, 0x000002, ..., 0x400000 (23 vectors); emit_count=23 and count_ok=1 with ENUM_VECTOR_COUNT_EN.
- weight=0 then weight=23: single vector 0x000000, then single vector 0x7FFFFF, each with out_last=1 and a done pulse; error stays 0.
- weight=24: error pulses once; busy, out_valid and done stay 0.
- weight=3, out_ready toggled randomly: out_vector stable whenever out_valid & !out_ready; 1771 distinct increasing vectors, each with popcount 3.
- weight=11, rst_n low after 100 handshakes: all outputs 0 immediately; start while busy earlier ignored; restart with weight=11 begins again at 0x0007FF.

Source files
------------

// File: rtl/popcount_weight_enumerator.sv
// popcount_weight_enumerator
// Streams every N-bit vector of Hamming weight k, in ascending numeric order,
// over a valid/ready handshake. Successors are produced by Gosper's hack so the
// stream runs at one vector per cycle.
// Optional build macro ENUM_VECTOR_COUNT_EN adds a handshake counter and a
// registered check of that count against C(N,k).

module popcount_weight_enumerator #(
   parameter int N = 23,  // vector width, 2..31
   parameter int W = 5    // weight port width, 2^W > N
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] weight,
   output logic         busy,
   output logic [N-1:0] out_vector,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_last,
   output logic         done,
   output logic         error
`ifdef ENUM_VECTOR_COUNT_EN
   ,
   output logic [24:0]  emit_count,
   output logic         count_ok
`endif
);

   localparam int CW = $clog2(N + 1);
   localparam logic [W-1:0] N_W = W'(N);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      FIN  = 2'd2
   } state_e;

   state_e         state_q, state_d;
   logic [N-1:0]   vec_q, vec_d;
   logic [W-1:0]   k_q, k_d;
   logic           valid_q, valid_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           error_q, error_d;

   // Gosper successor datapath, one bit wider than the vector so the carry
   // out of v + c is kept until the final truncation.
   logic [N:0]     v_ext;
   logic [N:0]     c_ext;
   logic [N:0]     r_ext;
   logic [N:0]     x_ext;
   logic [CW-1:0]  ctz;
   logic [N-1:0]   succ_vec;

   logic [N-1:0]   first_vec;
   logic [N-1:0]   last_vec;
   logic [W-1:0]   low_zeros;
   logic           is_last;
   logic           accept;
   logic           reject;
   logic           handshake;

   // Request decode and handshake detection shared by the FSM and the counter.
   always_comb begin
      accept    = (state_q == IDLE) && start && (weight <= N_W);
      reject    = (state_q == IDLE) && start && (weight >  N_W);
      handshake = (state_q == EMIT) && valid_q && out_ready;
   end

   // Lowest set bit, its sum with v, and the shifted-down ripple pattern.
   always_comb begin
      v_ext = {1'b0, vec_q};
      c_ext = v_ext & (~v_ext + (N+1)'(1));
      r_ext = v_ext + c_ext;
      x_ext = (v_ext ^ r_ext) >> 2;
   end

   // Priority encoder for ctz(c); scanning downward leaves the lowest set bit.
   always_comb begin
      ctz = '0;
      for (int i = N; i >= 0; i--) begin
         if (c_ext[i]) begin
            ctz = CW'(i);
         end
      end
   end

   // Successor vector, truncated back to N bits.
   always_comb begin
      succ_vec = N'(r_ext | (x_ext >> ctz));
   end

   // First vector (k low ones) for the requested weight, and the final vector
   // (k high ones) for the weight being enumerated. The final vector is the
   // complement of N-k low ones, which handles k=0 and k=N without special cases.
   always_comb begin
      first_vec = N'(((N+1)'(1) << weight) - (N+1)'(1));
      low_zeros = N_W - k_q;
      last_vec  = ~N'(((N+1)'(1) << low_zeros) - (N+1)'(1));
      is_last   = valid_q && (vec_q == last_vec);
   end

   // Next-state and next-output logic for the IDLE/EMIT/FIN controller.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // it unassigned, which would otherwise infer a latch.
      state_d = state_q;
      vec_d   = vec_q;
      k_d     = k_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      error_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               vec_d   = first_vec;
               k_d     = weight;
               valid_d = 1'b1;
               busy_d  = 1'b1;
               state_d = EMIT;
            end else if (reject) begin
               error_d = 1'b1;
            end
         end

         EMIT: begin
            // Without a handshake everything holds, so valid never drops early.
            if (handshake) begin
               if (is_last) begin
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = FIN;
               end else begin
                  vec_d = succ_vec;
               end
            end
         end

         FIN: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any enumeration in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vec_q   <= '0;
         k_q     <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, regardless of statement order.
         state_q <= state_d;
         vec_q   <= vec_d;
         k_q     <= k_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         error_q <= error_d;
      end
   end

   assign out_vector = vec_q;
   assign out_valid  = valid_q;
   assign out_last   = is_last;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;

`ifdef ENUM_VECTOR_COUNT_EN
   // Binomial coefficient evaluated at elaboration to fill the lookup table.
   function automatic longint binom(input int n, input int k);
      longint acc;
      acc = 1;
      if (k > n) begin
         return 0;
      end
      for (int i = 0; i < k; i++) begin
         acc = acc * longint'(n - i) / longint'(i + 1);
      end
      return acc;
   endfunction

   // NOTE: the table is constant wiring, not storage, so it needs no reset.
   // Sized to the full weight range so k_q indexes it without width games;
   // entries above N are never consulted.
   logic [24:0] binom_tab [0:(1<<W)-1];

   for (genvar gi = 0; gi < (1 << W); gi++) begin : g_binom
      assign binom_tab[gi] = 25'(binom(N, gi));
   end

   logic [24:0] emit_count_q, emit_count_d;
   logic        count_ok_q, count_ok_d;

   // Handshake counter; the final-count check is captured on the same edge
   // that raises done.
   always_comb begin
      emit_count_d = emit_count_q;
      count_ok_d   = count_ok_q;
      if (accept) begin
         emit_count_d = '0;
         count_ok_d   = 1'b0;
      end else if (handshake) begin
         emit_count_d = emit_count_q + 25'd1;
         if (is_last) begin
            count_ok_d = ((emit_count_q + 25'd1) == binom_tab[k_q]);
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         emit_count_q <= '0;
         count_ok_q   <= 1'b0;
      end else begin
         emit_count_q <= emit_count_d;
         count_ok_q   <= count_ok_d;
      end
   end

   assign emit_count = emit_count_q;
   assign count_ok   = count_ok_q;
`endif

endmodule

// File: tb/tb_popcount_weight_enumerator.sv
// Self-checking bench for popcount_weight_enumerator.
// Expected vectors come from an index-position combination model (ascending
// numeric order of k-subsets), pushed to a queue at start and popped on each
// handshake by a negedge monitor.

module tb_popcount_weight_enumerator;

   localparam int N = 23;
   localparam int W = 5;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] weight;
   logic         busy;
   logic [N-1:0] out_vector;
   logic         out_valid;
   logic         out_ready;
   logic         out_last;
   logic         done;
   logic         error;
`ifdef ENUM_VECTOR_COUNT_EN
   logic [24:0]  emit_count;
   logic         count_ok;
`endif

   popcount_weight_enumerator #(.N(N), .W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .weight     (weight),
      .busy       (busy),
      .out_vector (out_vector),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .done       (done),
      .error      (error)
`ifdef ENUM_VECTOR_COUNT_EN
      ,
      .emit_count (emit_count),
      .count_ok   (count_ok)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [N-1:0] vec;
      logic         last;
   } exp_t;

   exp_t         exp_q[$];
   exp_t         mon_e;
   int           n_tests = 0;
   int           n_fail  = 0;
   int           hs_count = 0;
   int           cur_k = 0;
   logic         hold_pending = 1'b0;
   logic [N-1:0] held_vec = '0;
   logic         have_prev = 1'b0;
   logic [N-1:0] prev_vec = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Monitor: stability while stalled, and scoreboard comparison per handshake.
   always @(negedge clk) begin
      if (rst_n !== 1'b1) begin
         hold_pending = 1'b0;
      end else begin
         if (hold_pending) begin
            check("stall_valid_held", out_valid, 1);
            check("stall_vector_held", out_vector, held_vec);
         end
         hold_pending = out_valid && !out_ready;
         held_vec     = out_vector;
         if (out_valid && out_ready) begin
            hs_count++;
            if (exp_q.size() == 0) begin
               check("unexpected_handshake", out_valid & out_ready, 0);
            end else begin
               mon_e = exp_q.pop_front();
               check("vector", out_vector, mon_e.vec);
               check("last", out_last, mon_e.last);
               check("popcount", $countones(out_vector), cur_k);
               if (have_prev) check("increasing", prev_vec < out_vector, 1);
               prev_vec  = out_vector;
               have_prev = 1'b1;
            end
         end
      end
   end

   // Model: k-subsets as sorted bit positions, advanced in ascending numeric order.
   task automatic push_expected(input int k, input int limit);
      int           p[32];
      int           i;
      int           cnt;
      bit           has_next;
      logic [N-1:0] v;
      exp_t         e;
      cnt = 0;
      for (int j = 0; j < 32; j++) p[j] = j;
      do begin
         v = '0;
         for (int j = 0; j < k; j++) v[p[j]] = 1'b1;
         i = 0;
         while (i < k && ((i == k - 1) ? (p[i] + 1 >= N) : (p[i] + 1 == p[i + 1]))) i++;
         has_next = (i < k);
         e.vec  = v;
         e.last = !has_next;
         exp_q.push_back(e);
         cnt++;
         if (has_next) begin
            p[i]++;
            for (int j = 0; j < i; j++) p[j] = j;
         end
      end while (has_next && cnt < limit);
   endtask

   task automatic do_start(input int k);
      @(posedge clk); #1;
      start     = 1'b1;
      weight    = W'(k);
      cur_k     = k;
      have_prev = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic drain(input bit rnd, input int budget, input string tag);
      int i;
      i = 0;
      while (exp_q.size() != 0 && i < budget) begin
         @(posedge clk); #1;
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         i++;
      end
      check({tag, "_drained"}, exp_q.size(), 0);
   endtask

   task automatic expect_done(input string tag);
      int i;
      i = 0;
      while (done !== 1'b1 && i < 4) begin
         @(posedge clk); #1;
         i++;
      end
      check({tag, "_done_latency"}, i, 0);
      check({tag, "_done"}, done, 1);
      check({tag, "_busy_at_done"}, busy, 0);
      check({tag, "_valid_at_done"}, out_valid, 0);
      @(posedge clk); #1;
      check({tag, "_done_pulse_end"}, done, 0);
      check({tag, "_busy_after"}, busy, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      rst_n     = 1'b0;
      start     = 1'b0;
      weight    = '0;
      out_ready = 1'b0;
      #12;
      check("rst_vector", out_vector, 0);
      check("rst_valid", out_valid, 0);
      check("rst_last", out_last, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // weight 2, always ready
      out_ready = 1'b1;
      push_expected(2, 1000);
      base = hs_count;
      do_start(2);
      check("k2_first_valid", out_valid, 1);
      check("k2_first_busy", busy, 1);
      check("k2_first_vector", out_vector, 23'h000003);
      drain(1'b0, 2000, "k2");
      check("k2_count", hs_count - base, 253);
      expect_done("k2");
`ifdef ENUM_VECTOR_COUNT_EN
      check("k2_emit_count", emit_count, 253);
      check("k2_count_ok", count_ok, 1);
`endif

      // weight 1
      push_expected(1, 1000);
      base = hs_count;
      do_start(1);
      drain(1'b0, 200, "k1");
      check("k1_count", hs_count - base, 23);
      expect_done("k1");
`ifdef ENUM_VECTOR_COUNT_EN
      check("k1_emit_count", emit_count, 23);
      check("k1_count_ok", count_ok, 1);
`endif

      // weight 0, then weight N
      push_expected(0, 10);
      do_start(0);
      check("k0_vector", out_vector, 23'h000000);
      check("k0_last", out_last, 1);
      check("k0_error", error, 0);
      drain(1'b0, 20, "k0");
      expect_done("k0");
      push_expected(23, 10);
      do_start(23);
      check("k23_vector", out_vector, 23'h7FFFFF);
      check("k23_last", out_last, 1);
      check("k23_error", error, 0);
      drain(1'b0, 20, "k23");
      expect_done("k23");

      // weight above N is rejected
      @(posedge clk); #1;
      start  = 1'b1;
      weight = 5'd24;
      @(posedge clk); #1;
      start = 1'b0;
      check("k24_error", error, 1);
      check("k24_busy", busy, 0);
      check("k24_valid", out_valid, 0);
      check("k24_done", done, 0);
      @(posedge clk); #1;
      check("k24_error_pulse_end", error, 0);
      check("k24_busy_after", busy, 0);
      check("k24_valid_after", out_valid, 0);
      check("k24_done_after", done, 0);

      // weight 3 with random backpressure
      push_expected(3, 5000);
      base = hs_count;
      do_start(3);
      drain(1'b1, 20000, "k3");
      check("k3_count", hs_count - base, 1771);
      expect_done("k3");
      out_ready = 1'b1;

      // weight 11: ignored start while busy, then reset after 100 handshakes
      push_expected(11, 100);
      do_start(11);
      check("k11_first_vector", out_vector, 23'h0007FF);
      @(posedge clk); #1;
      start  = 1'b1;
      weight = 5'd2;
      @(posedge clk); #1;
      start = 1'b0;
      check("k11_busy_ignored_start", busy, 1);
      drain(1'b0, 500, "k11");
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_vector", out_vector, 0);
      check("abort_valid", out_valid, 0);
      check("abort_last", out_last, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_error", error, 0);
`ifdef ENUM_VECTOR_COUNT_EN
      check("abort_emit_count", emit_count, 0);
      check("abort_count_ok", count_ok, 0);
`endif
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("abort_no_done", done, 0);

      // restart from the first vector, then stall the stream
      push_expected(11, 5);
      do_start(11);
      check("restart_vector", out_vector, 23'h0007FF);
      check("restart_busy", busy, 1);
      drain(1'b0, 50, "restart");
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("restart_stalled_valid", out_valid, 1);
      check("restart_stalled_busy", busy, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
